// File: rtl/op_unit_arbiter_if.sv
// rtl/op_unit_arbiter_if.sv - command/result bundle between requesters, consumer and op_unit_arbiter
// Purpose: groups both requester command channels, the result channel and the
//   delivered-result counter so the arbiter and its environment share one port.
// Ports (signals):
//   req0_*/req1_* : valid/ready handshake plus opcode and operands A..D per requester
//   res_*         : valid/ready result channel with data, requester ID and error flag
//   op_count      : results delivered since reset (CNT_W bits, wrapping)
// Modports: master = command sources + result consumer, slave = the arbiter.
interface op_unit_arbiter_if #(
  parameter int CNT_W = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic [3:0]       req0_op;
  logic [3:0]       req0_a;
  logic [3:0]       req0_b;
  logic [3:0]       req0_c;
  logic [3:0]       req0_d;
  logic             req1_valid;
  logic             req1_ready;
  logic [3:0]       req1_op;
  logic [3:0]       req1_a;
  logic [3:0]       req1_b;
  logic [3:0]       req1_c;
  logic [3:0]       req1_d;
  logic             res_valid;
  logic             res_ready;
  logic [3:0]       res_data;
  logic             res_id;
  logic             res_err;
  logic [CNT_W-1:0] op_count;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req0_c, req0_d,
    output req1_valid, req1_op, req1_a, req1_b, req1_c, req1_d,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_data, res_id, res_err, op_count
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req0_c, req0_d,
    input  req1_valid, req1_op, req1_a, req1_b, req1_c, req1_d,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_data, res_id, res_err, op_count
  );
endinterface

// File: rtl/op_unit_arbiter.sv
// rtl/op_unit_arbiter.sv - two-requester round-robin arbiter and sequencer for the 4-bit operator unit
// Purpose: accepts one command at a time from two requesters, evaluates the
//   selected 4-bit function in a registered execute stage and holds the tagged
//   result until the consumer takes it.
// Ports:
//   clk : clock, all state updates on the rising edge
//   rst : synchronous active-high reset
//   bus : op_unit_arbiter_if.slave (requester channels, result channel, op_count)
module op_unit_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  op_unit_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic             r_last;
  logic             r_id;
  logic [3:0]       r_op;
  logic [3:0]       r_a;
  logic [3:0]       r_b;
  logic [3:0]       r_c;
  logic [3:0]       r_d;

  logic             r_res_valid;
  logic [3:0]       r_res_data;
  logic             r_res_id;
  logic             r_res_err;
  logic [CNT_W-1:0] r_op_count;

  logic             w_grant;
  logic             w_grant_id;
  logic             w_deliver;
  logic [3:0]       w_result;
  logic             w_err;

  // Next state and handshake strobes. Grants are suppressed while rst is high
  // so no handshake can complete in a reset cycle.
  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_grant_id   = 1'b0;
    w_deliver    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!rst && (bus.req0_valid || bus.req1_valid)) begin
          w_grant      = 1'b1;
          // Contention goes to the requester that did not win last time;
          // otherwise the lone valid requester wins.
          w_grant_id   = (bus.req0_valid && bus.req1_valid) ? ~r_last : bus.req1_valid;
          w_state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        w_state_next = S_HOLD;
      end
      S_HOLD: begin
        if (bus.res_ready) begin
          w_deliver    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Operator datapath on the captured operands.
  always_comb begin
    w_result = 4'd0;
    w_err    = 1'b0;
    case (r_op)
      4'd0: w_result = r_b + r_c;
      4'd1: w_result = (r_c >= 4'd4) ? 4'd0 : (r_b >> r_c);
      4'd2: w_result = {3'b000, (r_a > r_b)};
      4'd3: w_result = {3'b000, (r_a == r_d)};
      4'd4: w_result = r_a & r_b;
      4'd5: w_result = {3'b000, (|r_b)};
      4'd6: w_result = {3'b000, ((r_a > r_b) || (r_a > r_d))};
      4'd7: w_result = {r_c[1:0], r_d[3:2]};
      4'd8: w_result = (r_a > r_b) ? r_a : r_b;
      default: begin
        w_result = 4'd0;
        w_err    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last      <= 1'b1;
      r_id        <= 1'b0;
      r_op        <= 4'd0;
      r_a         <= 4'd0;
      r_b         <= 4'd0;
      r_c         <= 4'd0;
      r_d         <= 4'd0;
      r_res_valid <= 1'b0;
      r_res_data  <= 4'd0;
      r_res_id    <= 1'b0;
      r_res_err   <= 1'b0;
      r_op_count  <= '0;
    end else begin
      if (w_grant) begin
        r_last <= w_grant_id;
        r_id   <= w_grant_id;
        r_op   <= w_grant_id ? bus.req1_op : bus.req0_op;
        r_a    <= w_grant_id ? bus.req1_a  : bus.req0_a;
        r_b    <= w_grant_id ? bus.req1_b  : bus.req0_b;
        r_c    <= w_grant_id ? bus.req1_c  : bus.req0_c;
        r_d    <= w_grant_id ? bus.req1_d  : bus.req0_d;
      end
      if (r_state == S_EXEC) begin
        r_res_valid <= 1'b1;
        r_res_data  <= w_result;
        r_res_id    <= r_id;
        r_res_err   <= w_err;
      end
      if (w_deliver) begin
        r_res_valid <= 1'b0;
        r_op_count  <= r_op_count + CNT_W'(1);
      end
    end
  end

  assign bus.req0_ready = w_grant & ~w_grant_id;
  assign bus.req1_ready = w_grant &  w_grant_id;
  assign bus.res_valid  = r_res_valid;
  assign bus.res_data   = r_res_data;
  assign bus.res_id     = r_res_id;
  assign bus.res_err    = r_res_err;
  assign bus.op_count   = r_op_count;

endmodule
